// File: rtl/hex_counter_pkg.sv
// Shared widths, limits and debounce state encoding for the hex counter.
package hex_counter_pkg;

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/hex_counter_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability FSM, one press pulse.
//
// state        | meaning
// RELEASED     | key idle (high), waiting for a low sample
// PRESS_WAIT   | key low, counting consecutive low samples
// PRESSED      | press accepted, waiting for a high sample
// RELEASE_WAIT | key high, counting consecutive high samples
module key_debounce
  import hex_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int                STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that enters a WAIT state is not counted, so the counter
  // reaching DEBOUNCE_CYCLES-1 on a matching sample completes the window.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q, sync2_q;
  db_state_e         state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;

  // Synchronizer, FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RELEASED;
      stab_q  <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  // Next state, counter and press pulse; counter clears on every transition.
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    press   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!sync2_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (stab_q == STAB_LAST) begin
          state_d = PRESSED;
          press   = 1'b1;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      PRESSED: begin
        if (sync2_q) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (stab_q == STAB_LAST) begin
          state_d = RELEASED;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: rtl/hex_counter.sv
// Up/down 4-bit counter driven by two debounced pushbuttons, with clear,
// wrap/saturate mode and a one-cycle change strobe.
module hex_counter
  import hex_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_up_n,
  input  logic             key_down_n,
  input  logic             clr,
  input  logic             sat,
  output logic [CNT_W-1:0] count,
  output logic             changed
);

  logic             up_press, down_press;
  logic [CNT_W-1:0] count_q, count_d;
  logic             changed_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_up_n),
    .press   (up_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_down_n),
    .press   (down_press)
  );

  // Next count: clear wins, simultaneous presses cancel, then up, then down.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (up_press && down_press) begin
      count_d = count_q;
    end else if (up_press) begin
      if (count_q == CNT_MAX) count_d = sat ? count_q : '0;
      else                    count_d = count_q + CNT_W'(1);
    end else if (down_press) begin
      if (count_q == '0) count_d = sat ? count_q : CNT_MAX;
      else               count_d = count_q - CNT_W'(1);
    end
  end

  // Count register and change strobe (high only when the value really moved).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      changed_q <= (count_d != count_q);
    end
  end

  assign count   = count_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_hex_counter.sv
// Directed bench for hex_counter with a 4-sample debounce window.
module tb_hex_counter;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset_n, key_up_n, key_down_n, clr, sat;
  logic [3:0] count;
  logic       changed;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;
  int c0;

  hex_counter #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .clr        (clr),
    .sat        (sat),
    .count      (count),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed === 1'b1) chg_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the selected keys low until the count-update edge (DB+3 edges).
  task automatic press(input logic up, input logic dn);
    key_up_n   = ~up;
    key_down_n = ~dn;
    repeat (DB + 3) tick();
  endtask

  task automatic release_keys();
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    repeat (DB + 6) tick();
  endtask

  initial begin
    reset_n = 1'b0; key_up_n = 1'b1; key_down_n = 1'b1; clr = 1'b0; sat = 1'b0;
    repeat (3) tick();
    chk("rst_count", 8'(count), 8'h0);
    chk("rst_changed", 8'(changed), 8'h0);
    reset_n = 1'b1;
    tick();

    // Held key: count moves exactly DB+3 edges after first low sample.
    c0 = chg_cnt;
    key_up_n = 1'b0;
    repeat (DB + 2) tick();
    chk("lat_before", 8'(count), 8'h0);
    tick();
    chk("lat_at", 8'(count), 8'h1);
    chk("lat_changed", 8'(changed), 8'h1);
    repeat (13) tick();
    chk("hold_count", 8'(count), 8'h1);
    chk("hold_pulses", 8'(chg_cnt - c0), 8'd1);
    release_keys();

    // Bouncing key never accepted.
    c0 = chg_cnt;
    for (int i = 0; i < 3; i++) begin
      key_up_n = 1'b0; repeat (2) tick();
      key_up_n = 1'b1; repeat (2) tick();
    end
    release_keys();
    chk("bounce_count", 8'(count), 8'h1);
    chk("bounce_pulses", 8'(chg_cnt - c0), 8'd0);

    // Clear from 1, then clear at 0 gives no pulse.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_count", 8'(count), 8'h0);
    chk("clr_changed", 8'(changed), 8'h1);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr0_count", 8'(count), 8'h0);
    chk("clr0_changed", 8'(changed), 8'h0);

    // Wrap mode.
    press(1'b0, 1'b1);
    chk("wrap_dn", 8'(count), 8'hF);
    chk("wrap_dn_chg", 8'(changed), 8'h1);
    release_keys();
    press(1'b1, 1'b0);
    chk("wrap_up", 8'(count), 8'h0);
    chk("wrap_up_chg", 8'(changed), 8'h1);
    release_keys();

    // Saturate mode.
    sat = 1'b1;
    press(1'b0, 1'b1);
    chk("sat_dn", 8'(count), 8'h0);
    chk("sat_dn_chg", 8'(changed), 8'h0);
    release_keys();
    sat = 1'b0;
    press(1'b0, 1'b1);
    chk("to_15", 8'(count), 8'hF);
    release_keys();
    sat = 1'b1;
    tick();
    chk("sat_toggle", 8'(count), 8'hF);
    press(1'b1, 1'b0);
    chk("sat_up", 8'(count), 8'hF);
    chk("sat_up_chg", 8'(changed), 8'h0);
    release_keys();
    sat = 1'b0;

    // Both keys on the same edge cancel.
    c0 = chg_cnt;
    press(1'b1, 1'b1);
    chk("both_count", 8'(count), 8'hF);
    release_keys();
    chk("both_pulses", 8'(chg_cnt - c0), 8'd0);

    // Clear beats an up pulse on the same edge at count 7.
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0);
      release_keys();
    end
    chk("to_7", 8'(count), 8'h7);
    key_up_n = 1'b0;
    repeat (DB + 2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_up_count", 8'(count), 8'h0);
    chk("clr_up_chg", 8'(changed), 8'h1);
    release_keys();

    // Reset during PRESS_WAIT discards the press; held key re-accepted.
    press(1'b1, 1'b0);
    chk("pre_rst", 8'(count), 8'h1);
    release_keys();
    key_up_n = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    chk("mid_rst_count", 8'(count), 8'h0);
    chk("mid_rst_chg", 8'(changed), 8'h0);
    reset_n = 1'b1;
    repeat (DB + 2) tick();
    chk("post_rst_before", 8'(count), 8'h0);
    tick();
    chk("post_rst_at", 8'(count), 8'h1);
    release_keys();

    // Sixteen up presses from 0 wrap back to 0.
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    c0 = chg_cnt;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_v;
      exp_v = 4'(i);
      press(1'b1, 1'b0);
      chk($sformatf("seq_%0d", i), 8'(count), 8'(exp_v));
      release_keys();
    end
    chk("seq_pulses", 8'(chg_cnt - c0), 8'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_counter.md
HEX_COUNTER -- requirements
Module: hex_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples needed to accept a key level change (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port key_up_n, input, 1 bit: raw asynchronous pushbutton, active-low, increments the count.
REQ-005 SHALL have port key_down_n, input, 1 bit: raw asynchronous pushbutton, active-low, decrements the count.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of the count, active-high.
REQ-007 SHALL have port sat, input, 1 bit: 1 = saturate at 0/15, 0 = wrap modulo 16.
REQ-008 SHALL have port count, output, 4 bits: current value; drives the 4-bit input of the downstream two-digit seven-segment decoder.
REQ-009 SHALL have port changed, output, 1 bit: one-cycle pulse in the cycle after count takes a new value.

Function
REQ-010 SHALL pass each key through a 2-flop synchronizer before any other logic uses it.
REQ-011 SHALL debounce each synchronized key with a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 SHALL move RELEASED->PRESS_WAIT when the synced key reads 0; PRESS_WAIT->RELEASED if it reads 1 before the stability counter reaches DEBOUNCE_CYCLES.
REQ-013 SHALL move PRESS_WAIT->PRESSED after DEBOUNCE_CYCLES consecutive 0 samples, asserting a one-cycle press pulse on that transition.
REQ-014 SHALL move PRESSED->RELEASE_WAIT on a synced 1; RELEASE_WAIT->RELEASED after DEBOUNCE_CYCLES consecutive 1 samples; RELEASE_WAIT->PRESSED on any 0; no pulse on release.
REQ-015 SHALL reset the stability counter on every state transition; counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-016 SHALL emit exactly one press pulse per accepted press regardless of hold duration (no auto-repeat).
REQ-017 SHALL update count on the clock edge where a pulse is high, with count priority: clr > (up and down both pulsing: no change) > up > down.
REQ-018 SHALL, with sat=0, wrap 15+1->0 and 0-1->15; with sat=1, hold 15 on up and 0 on down, asserting no changed pulse.
REQ-019 SHALL assert changed only when the registered count value differs from its previous value (clr at 0 gives no pulse).
REQ-020 SHALL give fixed latency: count changes DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw key low, given stable input.
REQ-021 SHALL sample sat at the count-update edge; changing sat never alters count by itself.

Reset
REQ-022 SHALL, while reset_n=0 at a rising edge, set count=0, changed=0, both FSMs=RELEASED, stability counters=0, synchronizer flops=1.
REQ-023 SHALL discard any press in progress at reset; a key still held after reset release SHALL be accepted as a new press after full debounce.

Structure
REQ-024 SHALL place CNT_W=4, CNT_MAX=4'hF and the debounce FSM state enum in package hex_counter_pkg.
REQ-025 SHALL implement synchronizer + FSM + pulse as sub-module key_debounce (ports clk, reset_n, key_n, press), instantiated twice.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-026 SHALL cover: reset, then key_up_n held low 20 cycles -> count 0->1 exactly 7 edges after first low sample, a single changed pulse.
REQ-027 SHALL cover: key_up_n bouncing 0/1 every 2 cycles for 12 cycles, then released -> count unchanged, changed never asserted.
REQ-028 SHALL cover: sat=0, count=15, up press -> 0; count=0, down press -> 15; sat=1 same presses -> 15 and 0 held, no changed pulse.
REQ-029 SHALL cover: both keys pressed on the same edge -> no count change; clr asserted with up pulse at count=7 -> count 0.
REQ-030 SHALL cover: reset_n pulsed low during PRESS_WAIT with key held -> count 0, then increments to 1 DEBOUNCE_CYCLES+3 edges after reset release.
REQ-031 SHALL cover: 16 sequential up presses from 0 with sat=0 -> count sequence 1..15,0, 16 changed pulses.
